// File: rtl/bram_cfg_pkg.sv
// Shared BRAM geometry, writer FSM state encoding and a constant clog2 helper
// for sizing counters.
package bram_cfg_pkg;

  localparam int BRAM_DEPTH = 2048;
  localparam int BRAM_AW    = 11;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } vbw_state_e;

  // Smallest width that can encode n distinct values (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vector_bram_writer_if.sv
// Control/data bundle of vector_bram_writer: the PL vector with its start/busy/done
// handshake, and the Zynq PS BRAM port A.
interface vector_bram_writer_if #(
  parameter int VLEN = 1
);
  import bram_cfg_pkg::*;

  logic [WORD_W*VLEN-1:0] vec;
  logic                   start;
  logic                   busy;
  logic                   done;

  logic [12:0]            bram_porta_0_addr;
  logic [WORD_W-1:0]      bram_porta_0_din;
  logic [WORD_W-1:0]      bram_porta_0_dout;
  logic                   bram_porta_0_en;
  logic                   bram_porta_0_we;

  modport master (
    output vec, start, bram_porta_0_addr, bram_porta_0_din, bram_porta_0_en, bram_porta_0_we,
    input  busy, done, bram_porta_0_dout
  );

  modport slave (
    input  vec, start, bram_porta_0_addr, bram_porta_0_din, bram_porta_0_en, bram_porta_0_we,
    output busy, done, bram_porta_0_dout
  );

endinterface

// File: rtl/blk_mem_gen_0.sv
// Behavioural stand-in for the Vivado true dual-port block RAM IP (2048 x 32,
// read-first, 1-cycle read latency); the generated IP replaces it in the project.
module blk_mem_gen_0
  import bram_cfg_pkg::*;
(
  input  logic               clka,
  input  logic               ena,
  input  logic [0:0]         wea,
  input  logic [BRAM_AW-1:0] addra,
  input  logic [WORD_W-1:0]  dina,
  output logic [WORD_W-1:0]  douta,
  input  logic               clkb,
  input  logic               enb,
  input  logic [0:0]         web,
  input  logic [BRAM_AW-1:0] addrb,
  input  logic [WORD_W-1:0]  dinb,
  output logic [WORD_W-1:0]  doutb
);

  logic [WORD_W-1:0] mem [BRAM_DEPTH];

  // Both ports share one clock in this design; a single process keeps the
  // array single-driven. Same-address collisions are undefined in the IP.
  logic unused_clkb;
  assign unused_clkb = clkb;

  always_ff @(posedge clka) begin
    if (enb && web[0]) begin
      mem[addrb] <= dinb;
    end
    if (ena && wea[0]) begin
      mem[addra] <= dina;
    end
    if (ena) begin
      douta <= mem[addra];
    end
    if (enb) begin
      doutb <= mem[addrb];
    end
  end

endmodule

// File: rtl/vec_write_seq.sv
// Copy sequencer: snapshots the PL vector on start and streams it word by word
// into BRAM port B. Optional VBW_AUTO_UPDATE_EN adds self-start on vector change.
module vec_write_seq
  import bram_cfg_pkg::*;
#(
  parameter int VLEN      = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W*VLEN-1:0] vec,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   enb,
  output logic                   web,
  output logic [BRAM_AW-1:0]     addrb,
  output logic [WORD_W-1:0]      dinb
);

  localparam int CW = clog2(VLEN + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(VLEN - 1);

  vbw_state_e             state_q, state_d;
  cnt_t                   cnt_q, cnt_d;
  logic [WORD_W*VLEN-1:0] shadow_q;
  logic                   start_eff;

`ifdef VBW_AUTO_UPDATE_EN
  logic first_q;

  // Forces one copy on the first IDLE cycle after reset, before any snapshot exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
    end else if (state_q == IDLE) begin
      first_q <= 1'b0;
    end
  end

  assign start_eff = start | first_q | (vec != shadow_q);
`else
  assign start_eff = start;
`endif

  // Snapshot is deliberately not reset; it only matters once a copy starts.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_eff) begin
      shadow_q <= vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port B strobes are decoded from state so reset drops we without a clock edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    enb     = 1'b0;
    web     = 1'b0;
    addrb   = '0;
    dinb    = '0;
    unique case (state_q)
      IDLE: begin
        if (start_eff) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        busy  = 1'b1;
        enb   = 1'b1;
        web   = 1'b1;
        addrb = BRAM_AW'(BASE_ADDR) + BRAM_AW'(cnt_q);
        dinb  = shadow_q[WORD_W*int'(cnt_q) +: WORD_W];
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/vector_bram_writer.sv
// Copies a flat 32*VLEN-bit PL vector into block RAM at BASE_ADDR.. on request;
// PS reads results through BRAM port A. Optional feature macro: VBW_AUTO_UPDATE_EN.
module vector_bram_writer
  import bram_cfg_pkg::*;
#(
  parameter int VLEN      = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_bram_writer_if.slave  bus
);

  if (VLEN < 1 || BASE_ADDR < 0 || VLEN + BASE_ADDR > BRAM_DEPTH) begin : g_bad_cfg
    $error("vector_bram_writer: VLEN=%0d BASE_ADDR=%0d exceeds BRAM depth %0d",
           VLEN, BASE_ADDR, BRAM_DEPTH);
  end

  logic               enb;
  logic               web;
  logic [BRAM_AW-1:0] addrb;
  logic [WORD_W-1:0]  dinb;
  logic [WORD_W-1:0]  unused_doutb;
  logic [1:0]         unused_addr_lsb;

  // PS addresses are byte addresses; the BRAM is word addressed.
  assign unused_addr_lsb = bus.bram_porta_0_addr[1:0];

  vec_write_seq #(
    .VLEN      (VLEN),
    .BASE_ADDR (BASE_ADDR)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .vec   (bus.vec),
    .start (bus.start),
    .busy  (bus.busy),
    .done  (bus.done),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb)
  );

  blk_mem_gen_0 u_bram (
    .clka  (clk),
    .ena   (bus.bram_porta_0_en),
    .wea   (bus.bram_porta_0_we),
    .addra (bus.bram_porta_0_addr[12:2]),
    .dina  (bus.bram_porta_0_din),
    .douta (bus.bram_porta_0_dout),
    .clkb  (clk),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (unused_doutb)
  );

endmodule
